// File: rtl/getir_denetleyici.sv
// Instruction fetch sequencer: reads one word at ps, hands it to the core for one cycle, repeats.
// Latency: 2 cycles per instruction with zero-wait memory, plus one cycle per memory wait cycle.
// Backpressure: holds bel_istek/bel_adres steady until bel_hazir; a stalled read trips ERROR after ZAMAN_ASIMI cycles.
//
// Ports:
//   saat, reset           clock, asynchronous active-high reset
//   baslat, dur           start/resume (level), stop request (pulse)
//   adim_modu             single-step: return to IDLE after every issue
//   ps                    core program counter, used as the fetch address
//   bel_istek/bel_adres   memory read request and address (FETCH only)
//   bel_hazir/bel_veri    memory read completion and data
//   buyruk                instruction to core; all-zero bubble outside ISSUE
//   mesgul/durdu/hata     status: FETCH or ISSUE / HALT / ERROR
//   sayac                 issued-instruction counter, wraps at 16 bits
module getir_denetleyici #(
    parameter int          ZAMAN_ASIMI = 16,
    parameter logic [31:0] EBREAK      = 32'h0010_0073
) (
    input  logic        saat,
    input  logic        reset,
    input  logic        baslat,
    input  logic        dur,
    input  logic        adim_modu,
    input  logic [31:0] ps,
    input  logic        bel_hazir,
    input  logic [31:0] bel_veri,
    output logic        bel_istek,
    output logic [31:0] bel_adres,
    output logic [31:0] buyruk,
    output logic        mesgul,
    output logic        durdu,
    output logic        hata,
    output logic [15:0] sayac
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        ISSUE = 3'd2,
        HALT  = 3'd3,
        ERROR = 3'd4
    } durum_t;

    // Wide enough to hold ZAMAN_ASIMI itself.
    localparam int SW = $clog2(ZAMAN_ASIMI + 1);

    durum_t          durum;
    durum_t          sonraki;
    logic [SW-1:0]   bekleme;
    logic [31:0]     komut;
    logic            durma_bekliyor;
    logic            hizali;

    assign hizali = (ps[1:0] == 2'b00);

    // The request and address follow ps combinationally in FETCH. ps cannot move
    // there because the core sees only the bubble while we fetch. Both fall to
    // zero the moment reset forces the state register back to IDLE.
    assign bel_istek = (durum == FETCH) && hizali;
    assign bel_adres = (durum == FETCH) ? ps : 32'h0000_0000;

    always_comb begin
        sonraki = durum;
        case (durum)
            IDLE: begin
                if (dur)
                    sonraki = HALT;
                else if (baslat)
                    sonraki = FETCH;
            end
            FETCH: begin
                // A misaligned pc is unrecoverable; a completed read beats the
                // timeout on the very cycle the wait count would expire.
                if (!hizali)
                    sonraki = ERROR;
                else if (bel_hazir)
                    sonraki = ISSUE;
                else if (bekleme == SW'(ZAMAN_ASIMI - 1))
                    sonraki = ERROR;
            end
            ISSUE: begin
                // A stop arriving during ISSUE itself is honoured right away
                // rather than costing one more fetch.
                if (durma_bekliyor || dur || (komut == EBREAK))
                    sonraki = HALT;
                else if (adim_modu)
                    sonraki = IDLE;
                else
                    sonraki = FETCH;
            end
            HALT: begin
                if (baslat && !dur)
                    sonraki = FETCH;
            end
            ERROR: begin
                sonraki = ERROR;
            end
            default: begin
                sonraki = ERROR;
            end
        endcase
    end

    always_ff @(posedge saat or posedge reset) begin
        if (reset) begin
            durum          <= IDLE;
            bekleme        <= '0;
            komut          <= 32'h0000_0000;
            durma_bekliyor <= 1'b0;
            buyruk         <= 32'h0000_0000;
            mesgul         <= 1'b0;
            durdu          <= 1'b0;
            hata           <= 1'b0;
            sayac          <= 16'h0000;
        end else begin
            durum  <= sonraki;
            mesgul <= (sonraki == FETCH) || (sonraki == ISSUE);
            durdu  <= (sonraki == HALT);
            hata   <= (sonraki == ERROR);

            // Counts only stalled, aligned FETCH cycles; any other cycle restarts it.
            if ((durum == FETCH) && hizali && !bel_hazir)
                bekleme <= bekleme + 1'b1;
            else
                bekleme <= '0;

            // buyruk is the instruction register gated to ISSUE, registered so the
            // core never sees a partially decoded word.
            if ((durum == FETCH) && (sonraki == ISSUE)) begin
                komut  <= bel_veri;
                buyruk <= bel_veri;
            end else begin
                buyruk <= 32'h0000_0000;
            end

            if (durum == ISSUE)
                sayac <= sayac + 16'd1;

            // Stops never abort a fetch; they are remembered until HALT is reached.
            if (sonraki == HALT)
                durma_bekliyor <= 1'b0;
            else if (dur && ((durum == FETCH) || (durum == ISSUE)))
                durma_bekliyor <= 1'b1;
        end
    end

endmodule

// File: tb/tb_getir_denetleyici.sv
module tb_getir_denetleyici;

    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic        saat = 1'b0;
    logic        reset = 1'b1;
    logic        baslat = 1'b0;
    logic        dur = 1'b0;
    logic        adim_modu = 1'b0;
    logic [31:0] ps;
    logic        bel_hazir = 1'b0;
    logic [31:0] bel_veri = 32'h0;
    logic        bel_istek;
    logic [31:0] bel_adres;
    logic [31:0] buyruk;
    logic        mesgul;
    logic        durdu;
    logic        hata;
    logic [15:0] sayac;

    getir_denetleyici #(.ZAMAN_ASIMI(16), .EBREAK(EBREAK)) dut (
        .saat      (saat),
        .reset     (reset),
        .baslat    (baslat),
        .dur       (dur),
        .adim_modu (adim_modu),
        .ps        (ps),
        .bel_hazir (bel_hazir),
        .bel_veri  (bel_veri),
        .bel_istek (bel_istek),
        .bel_adres (bel_adres),
        .buyruk    (buyruk),
        .mesgul    (mesgul),
        .durdu     (durdu),
        .hata      (hata),
        .sayac     (sayac)
    );

    always #5 saat = ~saat;

    // Core model: any non-bubble instruction advances the pc by one word.
    logic [31:0] core_ps;
    logic [31:0] ps_ofs = 32'h0;
    always @(posedge saat or posedge reset) begin
        if (reset)
            core_ps <= 32'h0;
        else if (buyruk != 32'h0)
            core_ps <= core_ps + 32'd4;
    end
    assign ps = core_ps + ps_ofs;

    // Memory model controls
    logic [31:0] mem [0:63];
    int          lat_fix  = 0;     // -1: random 0..3 wait cycles per read
    logic        mem_dead = 1'b0;  // never answer
    logic        force_hz = 1'b0;  // spurious bel_hazir regardless of request

    // Scoreboard
    typedef struct packed {
        logic [31:0] ins;
        logic [15:0] cnt;
    } beklenen_t;
    beklenen_t   exp_q[$];
    logic [15:0] m_cnt = 16'h0;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic expect_issue(input logic [31:0] w);
        beklenen_t e;
        m_cnt = m_cnt + 16'd1;
        e.ins = w;
        e.cnt = m_cnt;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge saat);
        reset  = 1'b1;
        baslat = 1'b0;
        dur    = 1'b0;
        repeat (2) @(negedge saat);
        reset = 1'b0;
        m_cnt = 16'h0;
    endtask

    task automatic pulse_start();
        @(negedge saat);
        baslat = 1'b1;
        @(negedge saat);
        baslat = 1'b0;
    endtask

    task automatic wait_stop(input string name, input int budget);
        int n = 0;
        while (!durdu && !hata && n < budget) begin
            @(negedge saat);
            n++;
        end
        chk(name, 32'(durdu), 32'd1);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (mesgul && n < budget) begin
            @(negedge saat);
            n++;
        end
        chk(name, 32'(mesgul), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    int          n;
    logic        adr_ok;
    int          plen;
    logic [31:0] w;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = EBREAK;

        fork
            // Memory responder: answers after the chosen number of wait cycles.
            begin
                int wcnt = 0;
                int cur_lat = 0;
                forever begin
                    @(negedge saat);
                    if (force_hz) begin
                        bel_hazir = 1'b1;
                        bel_veri  = 32'hDEAD_BEEF;
                    end else if (bel_istek && !mem_dead) begin
                        if (wcnt == 0)
                            cur_lat = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 3));
                        if (wcnt >= cur_lat) begin
                            bel_hazir = 1'b1;
                            bel_veri  = mem[bel_adres[7:2]];
                            wcnt      = 0;
                        end else begin
                            bel_hazir = 1'b0;
                            wcnt++;
                        end
                    end else begin
                        bel_hazir = 1'b0;
                        bel_veri  = 32'h0;
                        wcnt      = 0;
                    end
                end
            end
            // Monitor: every non-bubble word must be the next expected issue.
            begin
                beklenen_t e;
                forever begin
                    @(negedge saat);
                    if (!reset && buyruk != 32'h0) begin
                        if (exp_q.size() == 0) begin
                            chk("issue_unexpected", buyruk, 32'h0);
                        end else begin
                            e = exp_q.pop_front();
                            chk("issue_word", buyruk, e.ins);
                            chk("issue_count", 32'(sayac), 32'(e.cnt - 16'd1));
                            chk("issue_no_req", 32'(bel_istek), 32'd0);
                        end
                    end
                end
            end
        join_none

        // Reset state
        #3;
        chk("rst_istek", 32'(bel_istek), 32'd0);
        chk("rst_adres", bel_adres, 32'h0);
        chk("rst_buyruk", buyruk, 32'h0);
        chk("rst_mesgul", 32'(mesgul), 32'd0);
        chk("rst_durdu", 32'(durdu), 32'd0);
        chk("rst_hata", 32'(hata), 32'd0);
        chk("rst_sayac", 32'(sayac), 32'd0);

        // Zero-wait fetch, one addi then EBREAK
        lat_fix = 0;
        mem[0] = 32'h0050_0513;
        mem[1] = EBREAK;
        do_reset();
        expect_issue(32'h0050_0513);
        expect_issue(EBREAK);
        @(negedge saat);
        baslat = 1'b1;
        @(negedge saat);
        chk("c1_istek", 32'(bel_istek), 32'd1);
        chk("c1_adres", bel_adres, 32'h0);
        @(negedge saat);
        chk("c2_buyruk", buyruk, 32'h0050_0513);
        baslat = 1'b0;
        @(negedge saat);
        chk("c3_sayac", 32'(sayac), 32'd1);
        chk("c3_ps", core_ps, 32'd4);
        chk("c3_adres", bel_adres, 32'd4);
        wait_stop("c_halt", 20);
        chk("c_sayac_end", 32'(sayac), 32'd2);

        // Three wait cycles: request held four cycles at a constant address
        lat_fix = 3;
        mem[0] = 32'h00A0_0593;
        mem[1] = EBREAK;
        do_reset();
        expect_issue(32'h00A0_0593);
        expect_issue(EBREAK);
        pulse_start();
        n = 0;
        adr_ok = 1'b1;
        for (int k = 0; k < 20 && buyruk == 32'h0; k++) begin
            if (bel_istek) n++;
            if (bel_adres != 32'h0) adr_ok = 1'b0;
            @(negedge saat);
        end
        chk("w3_istek_cycles", 32'(n), 32'd4);
        chk("w3_adres_const", 32'(adr_ok), 32'd1);
        wait_stop("w3_halt", 40);
        chk("w3_sayac", 32'(sayac), 32'd2);

        // Read completing on the last permitted wait cycle is not a timeout
        lat_fix = 15;
        mem[0] = 32'h0010_0093;
        mem[1] = EBREAK;
        do_reset();
        expect_issue(32'h0010_0093);
        expect_issue(EBREAK);
        pulse_start();
        wait_stop("edge_halt", 100);
        chk("edge_hata", 32'(hata), 32'd0);
        chk("edge_sayac", 32'(sayac), 32'd2);

        // Memory never answers
        mem_dead = 1'b1;
        do_reset();
        pulse_start();
        n = 0;
        for (int k = 0; k < 40 && !hata; k++) begin
            if (bel_istek) n++;
            @(negedge saat);
        end
        chk("to_fetch_cycles", 32'(n), 32'd16);
        chk("to_hata", 32'(hata), 32'd1);
        chk("to_istek", 32'(bel_istek), 32'd0);
        baslat = 1'b1;
        repeat (5) @(negedge saat);
        chk("to_stuck_hata", 32'(hata), 32'd1);
        chk("to_stuck_istek", 32'(bel_istek), 32'd0);
        baslat = 1'b0;
        mem_dead = 1'b0;
        do_reset();
        chk("to_reset_hata", 32'(hata), 32'd0);

        // Misaligned pc
        ps_ofs = 32'd2;
        pulse_start();
        chk("mis_mesgul", 32'(mesgul), 32'd1);
        chk("mis_istek", 32'(bel_istek), 32'd0);
        @(negedge saat);
        chk("mis_hata", 32'(hata), 32'd1);
        ps_ofs = 32'd0;

        // Single-step, two starts
        lat_fix = -1;
        adim_modu = 1'b1;
        mem[0] = 32'h0000_0013 | 32'h100;
        mem[1] = 32'h0020_0113;
        mem[2] = 32'h0030_0193;
        do_reset();
        expect_issue(mem[0]);
        expect_issue(mem[1]);
        pulse_start();
        wait_idle("step1_idle", 20);
        pulse_start();
        wait_idle("step2_idle", 20);
        repeat (5) @(negedge saat);
        chk("step_sayac", 32'(sayac), 32'd2);
        chk("step_ps", core_ps, 32'd8);
        chk("step_istek", 32'(bel_istek), 32'd0);
        chk("step_durdu", 32'(durdu), 32'd0);
        adim_modu = 1'b0;

        // Stop during a fetch wait, then resume into EBREAK at address 8
        lat_fix = 3;
        mem[0] = 32'h0040_0213;
        mem[1] = 32'h0050_0293;
        mem[2] = EBREAK;
        do_reset();
        expect_issue(mem[0]);
        pulse_start();
        dur = 1'b1;
        @(negedge saat);
        dur = 1'b0;
        wait_stop("dur_halt", 20);
        chk("dur_sayac", 32'(sayac), 32'd1);
        chk("dur_ps", core_ps, 32'd4);
        expect_issue(mem[1]);
        expect_issue(EBREAK);
        pulse_start();
        wait_stop("eb_halt", 40);
        chk("eb_sayac", 32'(sayac), 32'd3);
        chk("eb_ps", core_ps, 32'd12);

        // Random programs terminated by EBREAK, random wait states
        lat_fix = -1;
        for (int r = 0; r < 6; r++) begin
            plen = int'($urandom_range(3, 12));
            for (int i = 0; i < plen; i++) begin
                w = $urandom | 32'h1;
                if (w == EBREAK) w = w ^ 32'h4;
                mem[i] = w;
            end
            mem[plen] = EBREAK;
            do_reset();
            for (int i = 0; i <= plen; i++) expect_issue(mem[i]);
            pulse_start();
            wait_stop("rnd_halt", 200);
            chk("rnd_sayac", 32'(sayac), 32'(plen + 1));
            chk("rnd_ps", core_ps, 32'(4 * (plen + 1)));
            chk("rnd_hata", 32'(hata), 32'd0);
        end
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        // Reset between edges in the middle of a fetch; late bel_hazir ignored
        lat_fix = 3;
        pulse_start();
        chk("mid_istek_before", 32'(bel_istek), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_istek", 32'(bel_istek), 32'd0);
        chk("mid_buyruk", buyruk, 32'h0);
        chk("mid_sayac", 32'(sayac), 32'd0);
        chk("mid_mesgul", 32'(mesgul), 32'd0);
        @(negedge saat);
        force_hz = 1'b1;
        reset = 1'b0;
        m_cnt = 16'h0;
        repeat (3) @(negedge saat);
        force_hz = 1'b0;
        chk("late_mesgul", 32'(mesgul), 32'd0);
        chk("late_sayac", 32'(sayac), 32'd0);
        chk("late_buyruk", buyruk, 32'h0);
        chk("sb_final", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
